// File: rtl/wb_tlc_mwr.sv
// Wishbone slave that turns single posted writes into PCIe MWr32 TLPs (3DW header, 1DW payload).
// Reads are refused with wb_err_o; the TX side is a two-beat 64-bit stream granted by tx_rdy.
module wb_tlc_mwr #(
  parameter logic [31:0] c_PCIE_BASE = 32'h0000_0000,
  parameter logic [2:0]  c_TC        = 3'd0
) (
  input  logic        clk_125,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [31:0] wb_dat_o,
  input  logic [15:0] comp_id,
  input  logic        tx_rdy,
  output logic        tx_req,
  output logic [63:0] tx_data,
  output logic        tx_st,
  output logic        tx_end,
  output logic        tx_dwen
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    BEAT0 = 3'd2,
    BEAT1 = 3'd3,
    ACK   = 3'd4
  } state_t;

  // Handshake: a Wishbone request is taken in IDLE when cyc & stb are high; it is
  // answered by one ack cycle (write) or one err cycle (read). On the TX side tx_req
  // is held until tx_rdy is sampled high, after which both beats go out back to back.
  state_t      state;
  logic [21:0] adr_q;
  logic [31:0] dat_q;
  logic [3:0]  sel_q;
  logic [7:0]  tag;

  logic [3:0]  first_be;
  logic [31:0] dw0;
  logic [31:0] dw1;
  logic [31:0] dw2;
  logic [31:0] payload;

  // Only dword-aligned address bits [23:2] reach the TLP; the rest are dropped.
  logic unused_bits;
  assign unused_bits = &{1'b0, wb_adr_i[31:24], wb_adr_i[1:0], c_PCIE_BASE[23:0]};

  assign first_be = {sel_q[0], sel_q[1], sel_q[2], sel_q[3]};
  assign dw0      = {1'b0, 2'b10, 5'b00000, 1'b0, c_TC, 4'b0000, 1'b0, 1'b0,
                     2'b00, 2'b00, 10'd1};
  assign dw1      = {comp_id, tag, 4'b0000, first_be};
  assign dw2      = {c_PCIE_BASE[31:24], adr_q, 2'b00};
  assign payload  = {dat_q[7:0], dat_q[15:8], dat_q[23:16], dat_q[31:24]};

  assign wb_dat_o = 32'h0000_0000;
  assign tx_dwen  = 1'b0;

  // Outputs are registered and set on the edge that enters the state they belong to.
  always_ff @(posedge clk_125) begin
    if (rst) begin
      state    <= IDLE;
      tag      <= 8'h00;
      adr_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      tx_req   <= 1'b0;
      tx_st    <= 1'b0;
      tx_end   <= 1'b0;
      tx_data  <= '0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      tx_req   <= 1'b0;
      tx_st    <= 1'b0;
      tx_end   <= 1'b0;
      tx_data  <= '0;
      case (state)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            if (!wb_we_i) begin
              wb_err_o <= 1'b1;
            end else if (wb_sel_i != 4'b0000) begin
              adr_q  <= wb_adr_i[23:2];
              dat_q  <= wb_dat_i;
              sel_q  <= wb_sel_i;
              tx_req <= 1'b1;
              state  <= REQ;
            end else begin
              wb_ack_o <= 1'b1;
              state    <= ACK;
            end
          end
        end
        REQ: begin
          if (tx_rdy) begin
            tx_st   <= 1'b1;
            tx_data <= {dw0, dw1};
            state   <= BEAT0;
          end else begin
            tx_req <= 1'b1;
          end
        end
        BEAT0: begin
          // The grant covers the whole TLP, so tx_rdy is not rechecked here.
          tx_end  <= 1'b1;
          tx_data <= {dw2, payload};
          state   <= BEAT1;
        end
        BEAT1: begin
          tag      <= tag + 8'd1;
          wb_ack_o <= 1'b1;
          state    <= ACK;
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_tlc_mwr.sv
// Directed bench for wb_tlc_mwr: Wishbone write/read driver, expected-beat queue,
// immediate-assertion checks and a one-line report.
module tb_wb_tlc_mwr;

  logic        clk_125 = 1'b0;
  logic        rst;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic [31:0] wb_dat_o;
  logic [15:0] comp_id;
  logic        tx_rdy;
  logic        tx_req;
  logic [63:0] tx_data;
  logic        tx_st;
  logic        tx_end;
  logic        tx_dwen;

  int total = 0;
  int bad   = 0;
  logic [7:0]  exp_tag;
  logic [63:0] exp_q[$];

  wb_tlc_mwr #(
    .c_PCIE_BASE(32'hA500_0000),
    .c_TC       (3'd0)
  ) dut (
    .clk_125 (clk_125),
    .rst     (rst),
    .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i),
    .wb_sel_i(wb_sel_i),
    .wb_we_i (wb_we_i),
    .wb_stb_i(wb_stb_i),
    .wb_cyc_i(wb_cyc_i),
    .wb_ack_o(wb_ack_o),
    .wb_err_o(wb_err_o),
    .wb_dat_o(wb_dat_o),
    .comp_id (comp_id),
    .tx_rdy  (tx_rdy),
    .tx_req  (tx_req),
    .tx_data (tx_data),
    .tx_st   (tx_st),
    .tx_end  (tx_end),
    .tx_dwen (tx_dwen)
  );

  // clock
  always #5 clk_125 = ~clk_125;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_b0(input logic [15:0] cid, input logic [7:0] t,
                                         input logic [3:0] s);
    return {32'h4000_0001, cid, t, 4'h0, s[0], s[1], s[2], s[3]};
  endfunction

  function automatic logic [63:0] exp_b1(input logic [31:0] a, input logic [31:0] d);
    return {8'hA5, a[23:2], 2'b00, d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic [37:0] ctrl_now();
    return {wb_ack_o, wb_err_o, tx_req, tx_st, tx_end, tx_dwen, wb_dat_o};
  endfunction

  // Driver: one Wishbone write, watching the TX bus until ack (bounded).
  // Inputs are scrambled after the accept edge to show the DUT uses its latched copy.
  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int hold, input bit drop_cyc, input bit drop_rdy,
                          output logic [63:0] b0, output logic [63:0] b1,
                          output int ack_at, output int req_cnt, output int st_cnt,
                          output int end_cnt, output int stray);
    b0 = '0; b1 = '0; ack_at = -1; req_cnt = 0; st_cnt = 0; end_cnt = 0; stray = 0;
    wb_adr_i = a; wb_dat_i = d; wb_sel_i = s;
    wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    tx_rdy = (hold == 0);
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk_125); #1;
      if (n == 1) begin
        wb_adr_i = ~a; wb_dat_i = ~d; wb_sel_i = ~s;
        if (drop_cyc) begin
          wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        end
      end
      if (tx_req) req_cnt++;
      if (tx_st) begin st_cnt++; b0 = tx_data; end
      if (tx_end) begin end_cnt++; b1 = tx_data; end
      if (!tx_st && !tx_end && tx_data != 64'h0) stray++;
      if (wb_ack_o && wb_err_o) stray++;
      if (tx_dwen || wb_err_o) stray++;
      if (drop_rdy && tx_st) tx_rdy = 1'b0;
      else tx_rdy = (n >= hold);
      if (wb_ack_o) begin
        ack_at = n;
        break;
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; tx_rdy = 1'b1;
    @(posedge clk_125); #1;
    if (wb_ack_o || tx_req) stray++;
  endtask

  // Scoreboarded TLP write: expected beats are queued from the bench model.
  task automatic do_tlp(input string nm, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int hold, input bit drop_cyc,
                        input bit drop_rdy);
    logic [63:0] b0, b1, e0, e1;
    int ack_at, rq, st, en, sy, exp_req;
    exp_q.push_back(exp_b0(comp_id, exp_tag, s));
    exp_q.push_back(exp_b1(a, d));
    wb_write(a, d, s, hold, drop_cyc, drop_rdy, b0, b1, ack_at, rq, st, en, sy);
    e0 = exp_q.pop_front();
    e1 = exp_q.pop_front();
    exp_req = (hold < 1) ? 1 : hold;
    check({nm, "_beat0"}, b0, e0);
    check({nm, "_beat1"}, b1, e1);
    check({nm, "_ack_at"}, 64'(ack_at), 64'(exp_req + 3));
    check({nm, "_req_cycles"}, 64'(rq), 64'(exp_req));
    check({nm, "_st_cnt"}, 64'(st), 64'd1);
    check({nm, "_end_cnt"}, 64'(en), 64'd1);
    check({nm, "_stray"}, 64'(sy), 64'd0);
    exp_tag = exp_tag + 8'd1;
  endtask

  initial begin
    logic [63:0] b0, b1;
    int ack_at, rq, st, en, sy;
    bit seen;

    // reset
    rst = 1'b1; wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    wb_we_i = 1'b0; wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    comp_id = 16'h0100; tx_rdy = 1'b1; exp_tag = 8'h00;
    repeat (3) @(posedge clk_125);
    #1;
    check("reset_ctrl", 64'(ctrl_now()), 64'h0);
    check("reset_data", tx_data, 64'h0);
    rst = 1'b0;
    @(posedge clk_125); #1;

    // reference write with literal beats
    wb_write(32'h0000_1234, 32'h1122_3344, 4'hF, 0, 1'b0, 1'b0,
             b0, b1, ack_at, rq, st, en, sy);
    check("ref_beat0", b0, 64'h4000_0001_0100_000F);
    check("ref_beat1", b1, 64'hA500_1234_4433_2211);
    check("ref_ack_at", 64'(ack_at), 64'd4);
    check("ref_stray", 64'(sy), 64'd0);
    exp_tag = 8'h01;

    // byte enable reversal
    do_tlp("sel_0001", 32'h0000_0040, 32'hDEAD_BEEF, 4'b0001, 0, 1'b0, 1'b0);
    do_tlp("sel_1000", 32'h00FF_FFFC, 32'h0102_0304, 4'b1000, 0, 1'b0, 1'b0);

    // grant withheld for 10 cycles
    do_tlp("hold10", 32'h0012_3458, 32'hCAFE_F00D, 4'b0110, 10, 1'b0, 1'b0);

    // read is refused
    wb_adr_i = 32'h0000_0100; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk_125); #1;
    check("read_err_hi", 64'({wb_err_o, wb_ack_o, tx_req}), 64'b100);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge clk_125); #1;
    check("read_err_lo", 64'({wb_err_o, wb_ack_o, tx_req}), 64'b000);

    // empty byte enable: ack with no TLP
    wb_write(32'h0000_0200, 32'h5555_AAAA, 4'h0, 0, 1'b0, 1'b0,
             b0, b1, ack_at, rq, st, en, sy);
    check("sel0_ack_at", 64'(ack_at), 64'd1);
    check("sel0_tlp", 64'({rq, st, en}), 64'h0);
    check("sel0_stray", 64'(sy), 64'd0);

    // tag untouched by the read and sel=0 write; cyc dropped in REQ; rdy dropped in BEAT0
    do_tlp("cyc_drop", 32'h0000_0300, 32'h8765_4321, 4'b1100, 3, 1'b1, 1'b0);
    do_tlp("rdy_drop", 32'h00AB_CDE0, 32'h0F0F_F0F0, 4'b0011, 0, 1'b0, 1'b1);

    // reset during BEAT1 abandons the TLP
    wb_adr_i = 32'h0000_0400; wb_dat_i = 32'h1357_9BDF; wb_sel_i = 4'hF;
    wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1; tx_rdy = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk_125); #1;
      if (tx_end) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst_mid_beat1_seen", 64'(seen), 64'd1);
    rst = 1'b1;
    @(posedge clk_125); #1;
    check("rst_mid_ctrl", 64'(ctrl_now()), 64'h0);
    check("rst_mid_data", tx_data, 64'h0);
    rst = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge clk_125); #1;
    check("rst_mid_no_ack", 64'(ctrl_now()), 64'h0);
    exp_tag = 8'h00;

    // 257 back-to-back writes: tags run 0..255 then wrap to 0
    for (int i = 0; i < 257; i++) begin
      do_tlp("b2b", 32'h0010_0000 + 32'(i * 4), 32'hC0DE_0000 ^ 32'(i * 32'h0101),
             4'((i % 15) + 1), 0, 1'b0, 1'b0);
    end
    check("b2b_tag_wrapped", 64'(exp_tag), 64'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_tlc_mwr.md
WB_TLC_MWR -- requirements
Module: wb_tlc_mwr

Interface
REQ-001 SHALL have parameter c_PCIE_BASE, default 32'h0000_0000; its bits [31:24] supply the upper PCIe address byte.
REQ-002 SHALL have parameter c_TC, default 3'd0; it is the traffic class placed in every header.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have the following ports, one per line (name, direction, width, meaning):
- clk_125  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- wb_adr_i  in  32  Wishbone byte address.
- wb_dat_i  in  32  write data, Wishbone byte order.
- wb_sel_i  in  4  byte selects.
- wb_we_i  in  1  write enable.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle.
- wb_ack_o  out  1  write done.
- wb_err_o  out  1  read rejected.
- wb_dat_o  out  32  read data, constant 0.
- comp_id  in  16  requester ID {bus, dev, func}.
- tx_rdy  in  1  core grants the TX bus.
- tx_req  out  1  TLP pending.
- tx_data  out  64  TLP beat.
- tx_st  out  1  first beat.
- tx_end  out  1  last beat.
- tx_dwen  out  1  only upper DW valid on last beat; always 0.

Function
REQ-005 SHALL implement an FSM with states IDLE, REQ, BEAT0, BEAT1, ACK.
REQ-006 IDLE: on wb_cyc_i & wb_stb_i & wb_we_i & (wb_sel_i != 0), latch adr, dat and sel, then go to REQ; later input changes are ignored until the next IDLE.
REQ-007 IDLE: on wb_cyc_i & wb_stb_i & wb_we_i & (wb_sel_i == 0), go to ACK; no TLP is sent and the tag is unchanged.
REQ-008 IDLE: on wb_cyc_i & wb_stb_i & ~wb_we_i, pulse wb_err_o for one cycle on the next edge and stay in IDLE; in the following cycle the same request is not accepted again unless stb is still high.
REQ-009 REQ: tx_req = 1; remain in REQ while tx_rdy = 0; on the edge where tx_rdy = 1 is sampled, go to BEAT0. tx_req is 0 from BEAT0 onward.
REQ-010 BEAT0: tx_st = 1, tx_end = 0, tx_data = {DW0, DW1}, with DW0 in [63:32].
REQ-011 BEAT1: tx_st = 0, tx_end = 1, tx_data = {DW2, payload}.
REQ-012 ACK: wb_ack_o = 1 for exactly one cycle; then go to IDLE.
REQ-013 Minimum latency from stb accept to ack, with tx_rdy already high: 4 cycles (REQ, BEAT0, BEAT1, ACK).
REQ-014 DW0 = {1'b0, 2'b10, 5'b00000, 1'b0, c_TC, 4'b0, 1'b0, 1'b0, 2'b00, 2'b00, 10'd1} (MWr32, 3DW header, length 1).
REQ-015 DW1 = {comp_id, tag[7:0], 4'b0000, first_be}.
REQ-016 first_be = {sel[0], sel[1], sel[2], sel[3]}, i.e. bit-reversed to PCIe byte order.
REQ-017 DW2 = {c_PCIE_BASE[31:24], adr[23:2], 2'b00}.
REQ-018 payload = {dat[7:0], dat[15:8], dat[23:16], dat[31:24]}, i.e. byte-swapped to PCIe order.
REQ-019 tag SHALL be an 8-bit counter incremented on the BEAT1 cycle, wrapping 8'hFF to 8'h00.
REQ-020 tx_data SHALL be 64'h0 and tx_st, tx_end, tx_dwen SHALL be 0 outside BEAT0/BEAT1.
REQ-021 If tx_rdy drops during BEAT0 or BEAT1, the FSM SHALL still complete the TLP (the grant covers the whole TLP).
REQ-022 If wb_cyc_i drops while in REQ, the FSM SHALL still send the TLP and pulse wb_ack_o (the posted write is committed).
REQ-023 wb_ack_o and wb_err_o SHALL never be high in the same cycle.

Reset
REQ-024 While rst = 1 at a clock edge, the FSM SHALL go to IDLE, tag SHALL be 0, and every output SHALL be 0.
REQ-025 Reset asserted mid-TLP (BEAT0 or BEAT1) SHALL force tx_st, tx_end, tx_req and tx_data to 0 on the next edge; the partial TLP is abandoned and no ack is given.

Verification
REQ-026 Write adr 32'h0000_1234, dat 32'h1122_3344, sel 4'hF, comp_id 16'h0100, tx_rdy = 1, c_PCIE_BASE = 32'hA500_0000 -> beat0 = 64'h4000_0001_0100_000F, beat1 = 64'hA500_1234_4433_2211, ack 4 cycles after accept.
REQ-027 Write with sel 4'b0001, then with sel 4'b1000 -> first_be = 4'b1000, then 4'b0001; tag = 0, then 1.
REQ-028 Hold tx_rdy = 0 for 10 cycles after accept -> tx_req high for 10 cycles, no tx_st, no ack; release tx_rdy -> TLP sent and ack pulsed.
REQ-029 Read request -> wb_err_o pulses for 1 cycle, no tx_req, tag unchanged; write with sel 4'h0 -> ack with no TLP.
REQ-030 256 back-to-back writes -> tags 0..255 in order, with the 257th write carrying tag 0.
REQ-031 Assert rst during BEAT1 -> next cycle all outputs are 0 and tag = 0; a subsequent write completes normally.
